// File: rtl/shot_collision_detector.sv
// Per-slot shot/enemy and shot/tower overlap accumulator for one video frame.
// Reports per-slot collision pulses at the frame boundary and keeps a saturating enemy-hit tally.
module shot_collision_detector #(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int HIT_COUNT_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic                       pause,
  input  logic [2:0]                 shotDrawingRequests,
  input  logic                       enemyDrawingRequest,
  input  logic                       towerDrawingRequest,
  input  logic                       clearHits,
  output logic [2:0]                 shotEnemyCollision,
  output logic [2:0]                 shotTowerCollision,
  output logic [HIT_COUNT_WIDTH-1:0] hitCount,
  output logic                       frameHitValid
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;
  localparam logic [7:0] MIN_OV = 8'(MIN_OVERLAP_PIXELS);
  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [HIT_COUNT_WIDTH+1:0] HC_MAX = {2'b00, {HIT_COUNT_WIDTH{1'b1}}};

  logic [0:0]                 state;
  logic [2:0][7:0]            encnt;
  logic [2:0][7:0]            twcnt;
  logic                       take_frame;
  logic                       accumulate;
  logic [2:0]                 hit_e;
  logic [2:0]                 hit_t;
  logic [1:0]                 hit_pop;
  logic [HIT_COUNT_WIDTH+1:0] hc_sum;
  logic [HIT_COUNT_WIDTH-1:0] hc_sat;

  always_comb begin
    take_frame = (state == ACCUM) && startOfFrame && !pause;
    // In REPORT the strobe is ignored, so that cycle's overlaps belong to the new frame.
    accumulate = !pause && ((state == REPORT) || !startOfFrame);
    for (int i = 0; i < 3; i++) begin
      hit_e[i] = (encnt[i] >= MIN_OV);
      hit_t[i] = (twcnt[i] >= MIN_OV) && !hit_e[i];
    end
    hit_pop = 2'(shotEnemyCollision[0]) + 2'(shotEnemyCollision[1]) + 2'(shotEnemyCollision[2]);
    hc_sum  = {2'b00, hitCount} + {{HIT_COUNT_WIDTH{1'b0}}, hit_pop};
    if (hc_sum > HC_MAX) begin
      hc_sat = {HIT_COUNT_WIDTH{1'b1}};
    end else begin
      hc_sat = hc_sum[HIT_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ACCUM;
      encnt              <= '0;
      twcnt              <= '0;
      shotEnemyCollision <= 3'b000;
      shotTowerCollision <= 3'b000;
      frameHitValid      <= 1'b0;
      hitCount           <= '0;
    end else begin
      state              <= take_frame ? REPORT : ACCUM;
      shotEnemyCollision <= take_frame ? hit_e : 3'b000;
      shotTowerCollision <= take_frame ? hit_t : 3'b000;
      frameHitValid      <= take_frame && (|{hit_e, hit_t});
      for (int i = 0; i < 3; i++) begin
        if (take_frame) begin
          encnt[i] <= 8'd0;
          twcnt[i] <= 8'd0;
        end else if (accumulate) begin
          if (shotDrawingRequests[i] && enemyDrawingRequest && (encnt[i] != CNT_MAX)) begin
            encnt[i] <= encnt[i] + 8'd1;
          end
          if (shotDrawingRequests[i] && towerDrawingRequest && (twcnt[i] != CNT_MAX)) begin
            twcnt[i] <= twcnt[i] + 8'd1;
          end
        end
      end
      // clearHits has priority, so a clear during REPORT drops that frame's hits.
      if (clearHits) begin
        hitCount <= '0;
      end else if (state == REPORT) begin
        hitCount <= hc_sat;
      end
    end
  end

endmodule

// File: tb/tb_shot_collision_detector.sv
// Bench for shot_collision_detector: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a frame-level reference model.
module tb_shot_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] shotDrawingRequests = 3'b000;
  logic       enemyDrawingRequest = 1'b0;
  logic       towerDrawingRequest = 1'b0;
  logic       clearHits = 1'b0;
  logic [2:0] shotEnemyCollision;
  logic [2:0] shotTowerCollision;
  logic [7:0] hitCount;
  logic       frameHitValid;

  int vectors = 0;
  int miscompares = 0;

  shot_collision_detector #(.MIN_OVERLAP_PIXELS(4), .HIT_COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .shotDrawingRequests(shotDrawingRequests), .enemyDrawingRequest(enemyDrawingRequest),
    .towerDrawingRequest(towerDrawingRequest), .clearHits(clearHits),
    .shotEnemyCollision(shotEnemyCollision), .shotTowerCollision(shotTowerCollision),
    .hitCount(hitCount), .frameHitValid(frameHitValid)
  );

  always #5 clk = ~clk;

  // Reference model: overlap tallies per slot, one pending report, running hit total.
  int m_en[3];
  int m_tw[3];
  bit m_report;
  logic [2:0] m_e, m_t;
  int m_hc;

  function automatic int popc(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_en[i] = 0; m_tw[i] = 0; end
    m_report = 0; m_e = 3'b000; m_t = 3'b000; m_hc = 0;
  endtask

  task automatic model_edge(input bit sof, input bit pse, input logic [2:0] req,
                            input bit en, input bit tw, input bit clr);
    bit frame_end;
    bit add;
    frame_end = !m_report && sof && !pse;
    add = !pse && (m_report || !sof);
    if (clr) m_hc = 0;
    else if (m_report) m_hc = (m_hc + popc(m_e) > 255) ? 255 : m_hc + popc(m_e);
    m_e = 3'b000; m_t = 3'b000;
    if (frame_end) begin
      for (int i = 0; i < 3; i++) begin
        if (m_en[i] >= 4) m_e[i] = 1'b1;
        else if (m_tw[i] >= 4) m_t[i] = 1'b1;
        m_en[i] = 0; m_tw[i] = 0;
      end
    end else if (add) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && en) m_en[i] = (m_en[i] < 255) ? m_en[i] + 1 : 255;
        if (req[i] && tw) m_tw[i] = (m_tw[i] < 255) ? m_tw[i] + 1 : 255;
      end
    end
    m_report = frame_end;
  endtask

  task automatic check(input string name, input logic [2:0] e, input logic [2:0] t,
                       input logic fv, input logic [7:0] hc);
    vectors++;
    if (shotEnemyCollision !== e || shotTowerCollision !== t || frameHitValid !== fv || hitCount !== hc) begin
      miscompares++;
      $display("FAIL %s: got e=%b t=%b fv=%b hc=%0d, want e=%b t=%b fv=%b hc=%0d", name,
               shotEnemyCollision, shotTowerCollision, frameHitValid, hitCount, e, t, fv, hc);
    end
  endtask

  // One clock: drive inputs, advance, update model, compare just after the edge.
  task automatic step(input string name, input bit sof, input bit pse, input logic [2:0] req,
                      input bit en, input bit tw, input bit clr);
    startOfFrame = sof; pause = pse; shotDrawingRequests = req;
    enemyDrawingRequest = en; towerDrawingRequest = tw; clearHits = clr;
    @(posedge clk);
    #1;
    model_edge(sof, pse, req, en, tw, clr);
    check(name, m_e, m_t, |{m_e, m_t}, 8'(m_hc));
  endtask

  task automatic frame(input string name, input logic [2:0] req, input int n, input bit clr_in_report);
    for (int k = 0; k < n; k++) step(name, 1'b0, 1'b0, req, 1'b1, 1'b0, 1'b0);
    step(name, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(name, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, clr_in_report);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_state", 3'b000, 3'b000, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit sof; bit pse; logic [2:0] req; bit en; bit tw; bit clr;
    logic [2:0] e; logic [2:0] t; logic fv; logic [7:0] hc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sof, input logic [2:0] req, input bit en, input bit tw,
                              input logic [2:0] e, input logic [2:0] t, input logic [7:0] hc);
    vec_t v;
    v.sof = sof; v.pse = 1'b0; v.req = req; v.en = en; v.tw = tw; v.clr = 1'b0;
    v.e = e; v.t = t; v.fv = |{e, t}; v.hc = hc;
    return v;
  endfunction

  initial begin
    #2;
    do_reset();

    // T1: four slot0/enemy overlaps, then strobe.
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000, 8'd0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 8'd0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 8'd1));
    // T2: three overlaps is below threshold; the next frame's four hit.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 8'd1));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 8'd1));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 8'd1));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 8'd1));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 8'd2));
    // T3: slot2 enemy 5 and tower 6 -> enemy wins.
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1'b0, 3'b100, 1'b1, 1'b1, 3'b000, 3'b000, 8'd2));
    tbl.push_back(mk(1'b0, 3'b100, 1'b0, 1'b1, 3'b000, 3'b000, 8'd2));
    tbl.push_back(mk(1'b1, 3'b100, 1'b1, 1'b1, 3'b100, 3'b000, 8'd2));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 8'd3));
    // Tower-only hit on slot0 does not add to the tally.
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1'b0, 3'b001, 1'b0, 1'b1, 3'b000, 3'b000, 8'd3));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b001, 8'd3));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 8'd3));

    foreach (tbl[i]) begin
      startOfFrame = tbl[i].sof; pause = tbl[i].pse; shotDrawingRequests = tbl[i].req;
      enemyDrawingRequest = tbl[i].en; towerDrawingRequest = tbl[i].tw; clearHits = tbl[i].clr;
      @(posedge clk);
      #1;
      model_edge(tbl[i].sof, tbl[i].pse, tbl[i].req, tbl[i].en, tbl[i].tw, tbl[i].clr);
      check($sformatf("table[%0d]", i), tbl[i].e, tbl[i].t, tbl[i].fv, tbl[i].hc);
    end

    // T4: drive the tally to 254, then saturate at 255, then clear during REPORT.
    do_reset();
    for (int f = 0; f < 84; f++) frame("t4_fill", 3'b111, 4, 1'b0);
    frame("t4_fill", 3'b001, 4, 1'b0);
    frame("t4_fill", 3'b001, 4, 1'b0);
    check("t4_at_254", 3'b000, 3'b000, 1'b0, 8'd254);
    frame("t4_sat", 3'b111, 4, 1'b0);
    check("t4_at_255", 3'b000, 3'b000, 1'b0, 8'd255);
    frame("t4_hold", 3'b111, 4, 1'b0);
    check("t4_hold_255", 3'b000, 3'b000, 1'b0, 8'd255);
    frame("t4_clear", 3'b111, 4, 1'b1);
    check("t4_clear_wins", 3'b000, 3'b000, 1'b0, 8'd0);

    // T5: pause freezes accumulation and masks strobes.
    for (int k = 0; k < 10; k++) begin
      step("t5_pause", 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
      if (k == 3 || k == 7) step("t5_pause_sof", 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) step("t5_run", 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    step("t5_sof", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("t5_pulse", 3'b001, 3'b000, 1'b1, 8'd0);
    step("t5_after", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("t5_tally", 3'b000, 3'b000, 1'b0, 8'd1);

    // T6a: reset with counters at 3; one more overlap afterwards must not reach the threshold.
    for (int k = 0; k < 3; k++) step("t6_fill", 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    do_reset();
    step("t6_one", 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    step("t6_sof", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("t6_no_pulse", 3'b000, 3'b000, 1'b0, 8'd0);
    // T6b: reset while a pulse is on the outputs clears it immediately and it never returns.
    for (int k = 0; k < 4; k++) step("t6_fill2", 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    step("t6_sof2", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("t6_pulse_before_reset", 3'b010, 3'b000, 1'b1, 8'd0);
    do_reset();
    step("t6_after_release", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("t6_lost", 3'b000, 3'b000, 1'b0, 8'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step("random",
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
